// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch sequencer for a combinational instruction ROM.
// Ports:
//   CLK, Reset_n            clock, asynchronous active-low reset
//   Start                   pulse: begin fetching at address 0 (from IDLE or HALT)
//   Stall                   freeze PC and instruction register
//   BranchEn/BranchRel      redirect fetch; relative targets are InstPC + signed BranchTarget
//   BranchTarget            absolute address or two's-complement offset
//   InstAddress / InstIn    ROM address (the PC) and the word read back
//   InstOut / InstPC        instruction register and the address it came from
//   InstValid / Halted      InstOut is live / a halt opcode stopped fetch
// Optional build macro FETCH_PERF_CNT_EN adds saturating CycleCount and FetchCount outputs.
module inst_fetch_ctrl #(
    parameter int IW = 9,
    parameter int DW = 32,
    parameter logic [3:0] HALT_OP = 4'b1111
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [IW-1:0] BranchTarget,
    output logic [IW-1:0] InstAddress,
    input  logic [DW-1:0] InstIn,
    output logic [DW-1:0] InstOut,
    output logic [IW-1:0] InstPC,
    output logic          InstValid,
    output logic          Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]   CycleCount,
    output logic [15:0]   FetchCount
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state;
    logic [IW-1:0] pc;
    logic [IW-1:0] target;
    logic halt_hit;
    // IW-bit addition wraps exactly like a sign-extended add truncated to IW bits
    assign target = BranchRel ? InstPC + BranchTarget : BranchTarget;
    assign halt_hit = InstIn[DW-1:DW-4] == HALT_OP;
    assign InstAddress = pc;
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pc        <= '0;
            InstOut   <= '0;
            InstPC    <= '0;
            InstValid <= 1'b0;
            Halted    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            CycleCount <= '0;
            FetchCount <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        pc    <= '0;
                        state <= RUN;
`ifdef FETCH_PERF_CNT_EN
                        CycleCount <= '0;
                        FetchCount <= '0;
`endif
                    end
                end
                RUN: begin
`ifdef FETCH_PERF_CNT_EN
                    if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
`endif
                    if (!Stall) begin
                        if (BranchEn) begin
                            // squash the word read this cycle: one-bubble penalty
                            InstValid <= 1'b0;
                            pc        <= target;
                        end else begin
                            InstOut   <= InstIn;
                            InstPC    <= pc;
                            InstValid <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
                            if (FetchCount != 16'hFFFF) FetchCount <= FetchCount + 16'd1;
`endif
                            if (halt_hit) begin
                                state  <= HALT;
                                Halted <= 1'b1;
                            end else begin
                                pc <= pc + IW'(1);
                            end
                        end
                    end
                end
                HALT: begin
                    InstValid <= 1'b0;
                    if (Start) begin
                        pc     <= '0;
                        Halted <= 1'b0;
                        state  <= RUN;
`ifdef FETCH_PERF_CNT_EN
                        CycleCount <= '0;
                        FetchCount <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
